// File: rtl/fifo_ctrl_module_if.sv
// Request/status bundle between a producer/consumer pair and the FIFO control stage.
// The master side issues requests; the slave side (the controller) drives RAM controls and flags.
interface fifo_ctrl_module_if #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int RAM_AW = 4
);
  logic              wr_req;
  logic [DW-1:0]     wr_data;
  logic              rd_req;
  logic              clr_err;
  logic              write_signal;
  logic [RAM_AW-1:0] write_addr;
  logic [DW-1:0]     data_in;
  logic              read_signal;
  logic [RAM_AW-1:0] read_addr;
  logic              rd_valid;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_req, wr_data, rd_req, clr_err,
    input  write_signal, write_addr, data_in, read_signal, read_addr, rd_valid,
    input  count, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_req, wr_data, rd_req, clr_err,
    output write_signal, write_addr, data_in, read_signal, read_addr, rd_valid,
    output count, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_module.sv
// FIFO control stage for an 8-entry dual-address RAM: accepts requests, drives RAM
// write/read strobes and addresses, and tracks occupancy, level flags and sticky errors.
module fifo_ctrl_module #(
  parameter int DW       = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int RAM_AW   = 4,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_ctrl_module_if.slave  bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          rd_valid_reg;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;

  logic full, empty, rd_acc, wr_acc;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  // A write into a full FIFO is only safe when the same cycle frees a slot.
  // Strobes are qualified with rst_n so the RAM sees nothing while reset is held.
  assign rd_acc = bus.rd_req & ~empty & rst_n;
  assign wr_acc = bus.wr_req & (~full | rd_acc) & rst_n;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (wr_acc) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_acc) rd_ptr_next = rd_ptr_reg + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // Clear first so a coincident error event takes priority.
    if (bus.clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (bus.wr_req & ~wr_acc) overflow_next  = 1'b1;
    if (bus.rd_req & empty)   underflow_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      rd_valid_reg  <= rd_acc;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign bus.write_signal = wr_acc;
  assign bus.read_signal  = rd_acc;
  assign bus.data_in      = bus.wr_data;
  assign bus.write_addr   = {{(RAM_AW-AW){1'b0}}, wr_ptr_reg};
  assign bus.read_addr    = {{(RAM_AW-AW){1'b0}}, rd_ptr_reg};
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.count        = count_reg;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_reg >= AF_C);
  assign bus.almost_empty = (count_reg <= AE_C);
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule
